mac_dot_pipe: RTL and testbench
===============================

Name: mac_dot_pipe

Overview:
Pipelined, parametrised fixed-point dot-product accumulator, the next generation of the single-lane MAC.
- Each accepted beat multiplies LANES signed Q-format operand pairs and sums the lane products.
- Beats are accumulated across a multi-beat vector, with a bias added on the first beat.
- A saturated ACC_W result is produced on the last beat, behind a valid/ready output handshake.
- Sits between the operand/weight buffers and the activation/writeback stage of the accelerator datapath.

Parameters:
LANES, 4, number of parallel multiply lanes (1..16)
WIDTH, 16, operand width, signed two's complement
FRAC, 12, fractional bits of operands and result (0 <= FRAC < WIDTH)
ACC_W, 32, accumulator/result width, signed, ACC_W >= WIDTH+2
ROUND, 0, 0 = truncate (arithmetic shift, floor); 1 = round half up (add 2^(FRAC-1) before shift); ignored when FRAC=0

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  beat present
in_ready  out  1  beat accepted when in_valid & in_ready
in_a  in  LANES*WIDTH  lane i operand at bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  lane i operand, same packing
in_last  in  1  final beat of vector
bias  in  ACC_W  Q(FRAC) bias; sampled only on the first beat of a vector
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  ACC_W  saturated Q(FRAC) result
out_sat  out  1  saturation occurred anywhere in this vector
busy  out  1  any pipeline stage valid, or out_valid

Behaviour:
- Reset: all stage valids=0, first-beat flag=1, out_valid=0, out_data=0, out_sat=0, busy=0. in_ready=1 after reset deasserts.
- Asserting reset mid-vector discards the partial accumulation and any held result. The next accepted beat is treated as a first beat.
- Global stall: en = !(out_valid & !out_ready). in_ready = en. All stages advance only when en=1, so no result is ever dropped.
- S1 (per lane): p = a*b, full 2*WIDTH signed product.
  - If ROUND=1 and FRAC>0, add 2^(FRAC-1).
  - Then arithmetic shift right by FRAC and sign-extend to ACC_W.
  - Register S1 together with valid, last, first, and bias sideband.
- S2: sum the LANES lane values at ACC_W+clog2(LANES) bits. Saturate to the ACC_W range and register; set the sat sideband on clip.
- S3 (accumulate):
  - First beat: acc = sat(bias + sum).
  - Otherwise: acc = sat(acc + sum).
  - The add is computed at ACC_W+1 bits and clipped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - vec_sat is sticky: set on any S2 or S3 clip, and cleared on the first beat of a new vector.
- First-beat flag: set by reset and by acceptance of an in_last beat. Cleared by acceptance of any non-last beat. The flag travels with the beat.
- Output: when the last beat completes S3, out_data <= acc, out_sat <= vec_sat | this-beat sat, out_valid <= 1.
- Latency: result visible 3 rising edges after the accepting edge (accepting edge counts as the first), absent stalls. Throughput: 1 beat/cycle.
- Handshake: out_data and out_sat are held stable while out_valid & !out_ready.
  - A completing last beat cannot collide with a held result, because en=0 freezes S3.
  - On an edge with out_valid & out_ready and a last beat completing S3, out_valid stays 1 with the new data.
- Single-beat vectors (in_last on the first beat) are legal: result = sat(bias + sum).
- Bubbles (in_valid=0) propagate as invalid stages and do not alter acc.

Decomposition:
- Shared package fxp_pkg:
  - default WIDTH/FRAC/ACC_W constants;
  - a signed saturate function (value, target width);
  - a clog2 constant function;
  - lane-slice indexing helper.
- Sub-module fxp_mul_round: one lane's multiply, round, shift and sign-extend, parametrised by WIDTH/FRAC/ACC_W/ROUND, instantiated LANES times in S1.

Test Plan:
1. Defaults, single beat, in_last=1, all a=0x1000 (1.0), all b=0x2000 (2.0), bias=0 -> after 3 cycles out_valid=1, out_data=0x00008000 (8.0), out_sat=0.
2. 3-beat vector, bias=0x1000, each beat a=0x1000, b=0x0800 on all lanes -> out_data=0x1000+3*0x2000=0x00007000, exactly one out_valid pulse.
3. Backpressure: out_ready=0 for 5 cycles while the next vector streams -> in_ready=0 after the first result appears, out_data stable, second vector's result correct once out_ready=1.
4. Saturation: a=b=0x7FFF on all lanes, bias=0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1. With bias=0x80000000 and a=0x8000, b=0x7FFF -> out_data=0x80000000, out_sat=1. The next clean vector -> out_sat=0.
5. Rounding, LANES=1: a=0x0001, b=0x0800 -> ROUND=0 gives 0, ROUND=1 gives 1. a=0xFFFF, b=0x0800 -> ROUND=0 gives 0xFFFFFFFF, ROUND=1 gives 0.
6. Reset after 2 beats of a 4-beat vector -> out_valid=0, busy=0. A fresh single-beat vector with bias=5 and zero operands -> out_data=5.

Source files
------------

// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point helpers for the dot-product datapath.
//   - default lane count, operand width, fraction bits, accumulator width
//   - wide_t: scratch type wide enough for any intermediate sum
//   - clog2:      ceiling log2 for sizing adder trees
//   - lane_lsb:   bit offset of a lane inside a packed lane bus
//   - sat_signed: clip a signed value to a signed target width
//   - sat_hit:    1 when sat_signed would clip
package fxp_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 12;
  localparam int DEF_ACC_W = 32;

  localparam int SAT_MAX_W = 128;

  typedef logic signed [SAT_MAX_W-1:0] wide_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  function automatic logic sat_hit(input wide_t v, input int unsigned w);
    return sat_signed(v, w) != v;
  endfunction

endpackage

// File: rtl/fxp_mul_round.sv
// fxp_mul_round: one multiply lane. Full-precision signed product, optional
// round-half-up, arithmetic shift right by FRAC, sign-extended to ACC_W.
// Purely combinational; the caller registers the result.
// Ports:
//   a, b : WIDTH-bit signed Q(FRAC) operands
//   y    : ACC_W-bit signed Q(FRAC) lane product
module fxp_mul_round
  import fxp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = DEF_ACC_W,
  parameter int ROUND = 0
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] y
);

  // One spare bit so the rounding add can never wrap the product.
  localparam int PW = 2 * WIDTH + 1;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [PW-1:0] RND =
    (ROUND != 0 && FRAC > 0) ? (PW'(1) <<< RSH) : '0;

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = p + RND;
    return r >>> FRAC;
  endfunction

  logic signed [PW-1:0] prod;

  always_comb begin
    prod = PW'(a) * PW'(b);
    y    = ACC_W'(round_shift(prod));
  end

endmodule

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: pipelined LANES-wide fixed-point dot-product accumulator.
// Each accepted beat multiplies LANES operand pairs, sums them, and adds the
// sum into a per-vector accumulator (seeded with bias on the first beat).
// The saturated result is presented on the last beat behind valid/ready.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : input beat handshake
//   in_a, in_b           : packed lane operands, lane i at [i*WIDTH +: WIDTH]
//   in_last              : final beat of the vector
//   bias                 : Q(FRAC) bias, used on the first beat only
//   out_valid/out_ready  : result handshake
//   out_data, out_sat    : saturated result and sticky saturation flag
//   busy                 : any beat in flight or result pending
module mac_dot_pipe
  import fxp_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = DEF_ACC_W,
  parameter int ROUND = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  input  logic                     in_last,
  input  logic [ACC_W-1:0]         bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int SUM_W = ACC_W + clog2(LANES);
  localparam int AW1   = ACC_W + 1;

  function automatic logic signed [ACC_W-1:0] clip_acc(input wide_t v);
    return ACC_W'(sat_signed(v, ACC_W));
  endfunction

  function automatic logic clip_hit(input wide_t v);
    return sat_hit(v, ACC_W);
  endfunction

  logic en;
  logic accept;
  logic first_beat;

  // A held, unconsumed result freezes every stage so nothing is overwritten.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_beat <= 1'b1;
    end else if (accept) begin
      first_beat <= in_last;
    end
  end

  // ---- S1: per-lane multiply, round, shift ----
  logic signed [ACC_W-1:0] lane_y [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_mul_round #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ACC_W (ACC_W),
      .ROUND (ROUND)
    ) u_mul (
      .a (in_a[lane_lsb(i, WIDTH) +: WIDTH]),
      .b (in_b[lane_lsb(i, WIDTH) +: WIDTH]),
      .y (lane_y[i])
    );
  end

  logic                    vld_p0;
  logic                    last_p0;
  logic                    first_p0;
  logic signed [ACC_W-1:0] bias_p0;
  logic signed [ACC_W-1:0] lane_p0 [LANES];

  always_ff @(posedge clk) begin
    if (en) begin
      lane_p0  <= lane_y;
      last_p0  <= in_last;
      first_p0 <= first_beat;
      bias_p0  <= bias;
    end
  end

  // ---- S2: lane sum and clip ----
  logic signed [SUM_W-1:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(lane_p0[i]);
    end
  end

  logic                    vld_p1;
  logic                    last_p1;
  logic                    first_p1;
  logic                    ssat_p1;
  logic signed [ACC_W-1:0] bias_p1;
  logic signed [ACC_W-1:0] sum_p1;

  always_ff @(posedge clk) begin
    if (en) begin
      sum_p1   <= clip_acc(wide_t'(lane_sum));
      ssat_p1  <= clip_hit(wide_t'(lane_sum));
      last_p1  <= last_p0;
      first_p1 <= first_p0;
      bias_p1  <= bias_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
    end
  end

  // ---- S3: accumulate, clip, publish on last beat ----
  logic signed [ACC_W-1:0] acc_p2;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [AW1-1:0]   acc_add;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    asat;
  logic                    vec_sat;
  logic                    beat_sat;

  always_comb begin
    acc_base = first_p1 ? bias_p1 : acc_p2;
    acc_add  = AW1'(acc_base) + AW1'(sum_p1);
    acc_nxt  = clip_acc(wide_t'(acc_add));
    asat     = clip_hit(wide_t'(acc_add));
    // First beat starts a fresh sticky flag.
    beat_sat = (first_p1 ? 1'b0 : vec_sat) | ssat_p1 | asat;
  end

  always_ff @(posedge clk) begin
    if (en && vld_p1) begin
      acc_p2 <= acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (vld_p1) begin
        vec_sat <= beat_sat;
      end
      // With en=1 any presented result is being consumed this edge.
      if (vld_p1 && last_p1) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
        out_sat   <= beat_sat;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = vld_p0 | vld_p1 | out_valid;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe: main 4-lane instance plus two single-lane
// instances (truncate and round) driven together for the rounding vectors.
module tb_mac_dot_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_last;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  // single-lane instances
  logic        r_valid;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_last;
  logic [31:0] r_bias;
  logic        r_ready;
  logic        r0_in_ready, r1_in_ready;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_data, r1_data;
  logic        r0_sat, r1_sat;
  logic        r0_busy, r1_busy;

  mac_dot_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  mac_dot_pipe #(.LANES(1), .ROUND(0)) dut_r0 (
    .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r0_in_ready),
    .in_a(r_a), .in_b(r_b), .in_last(r_last), .bias(r_bias),
    .out_valid(r0_valid), .out_ready(r_ready), .out_data(r0_data),
    .out_sat(r0_sat), .busy(r0_busy)
  );

  mac_dot_pipe #(.LANES(1), .ROUND(1)) dut_r1 (
    .clk(clk), .reset(reset), .in_valid(r_valid), .in_ready(r1_in_ready),
    .in_a(r_a), .in_b(r_b), .in_last(r_last), .bias(r_bias),
    .out_valid(r1_valid), .out_ready(r_ready), .out_data(r1_data),
    .out_sat(r1_sat), .busy(r1_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  exp_t        q_main[$];
  logic [31:0] q_r0[$];
  logic [31:0] q_r1[$];
  exp_t        mon_e;
  logic [31:0] mon_r0;
  logic [31:0] mon_r1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: result 0x%0h presented with nothing expected", name, act);
  endtask

  // main scoreboard monitor: pop on every handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q_main.size() == 0) begin
        unexpected("main_extra_result", out_data);
      end else begin
        mon_e = q_main.pop_front();
        check("main_data", out_data, mon_e.data);
        check("main_sat", 32'(out_sat), 32'(mon_e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && r0_valid && r_ready) begin
      if (q_r0.size() == 0) begin
        unexpected("r0_extra_result", r0_data);
      end else begin
        mon_r0 = q_r0.pop_front();
        check("round0_data", r0_data, mon_r0);
        check("round0_sat", 32'(r0_sat), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && r1_valid && r_ready) begin
      if (q_r1.size() == 0) begin
        unexpected("r1_extra_result", r1_data);
      end else begin
        mon_r1 = q_r1.pop_front();
        check("round1_data", r1_data, mon_r1);
        check("round1_sat", 32'(r1_sat), 32'd0);
      end
    end
  end

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic push(input logic [31:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    q_main.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic last, input logic [31:0] bv);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    bias     = bv;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || q_main.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(q_main.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    r_valid   = 1'b0;
    r_a       = '0;
    r_b       = '0;
    r_last    = 1'b1;
    r_bias    = '0;
    r_ready   = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r_busy", 32'({r0_busy, r1_busy}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_r_in_ready", 32'({r0_in_ready, r1_in_ready}), 32'd3);

    // single beat 1.0*2.0 x4 lanes = 8.0, result on the third edge
    push(32'h0000_8000, 1'b0);
    send(rep(16'h1000), rep(16'h2000), 1'b1, 32'h0);
    check("t1_lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_edge2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_edge3", 32'(out_valid), 32'd1);
    drain("t1");

    // 3-beat vector; bias on later beats must be ignored
    push(32'h0000_7000, 1'b0);
    send(rep(16'h1000), rep(16'h0800), 1'b0, 32'h0000_1000);
    send(rep(16'h1000), rep(16'h0800), 1'b0, 32'h0BAD_0000);
    send(rep(16'h1000), rep(16'h0800), 1'b1, 32'h0BAD_0000);
    drain("t2");

    // truncation floors negatives: -0.5 lsb per lane -> -1 each
    push(32'hFFFF_FFFC, 1'b0);
    send(rep(16'hFFFF), rep(16'h0800), 1'b1, 32'h0);
    drain("floor");

    // backpressure: result A held while vector B streams in
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    fork
      begin
        push(32'h0000_8000, 1'b0);
        send(rep(16'h1000), rep(16'h2000), 1'b1, 32'h0);
        // lanes 1.0, 2.0, -1.0, 0.5 -> 2.5 per beat; 3 beats - 1.0 = 6.5
        push(32'h0000_6800, 1'b0);
        send({16'h0800, 16'hF000, 16'h2000, 16'h1000}, rep(16'h1000), 1'b0, 32'hFFFF_F000);
        send({16'h0800, 16'hF000, 16'h2000, 16'h1000}, rep(16'h1000), 1'b0, 32'h0);
        send({16'h0800, 16'hF000, 16'h2000, 16'h1000}, rep(16'h1000), 1'b1, 32'h0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
          check("bp_in_ready_low", 32'(in_ready), 32'd0);
          check("bp_hold_valid", 32'(out_valid), 32'd1);
          check("bp_hold_data", out_data, 32'h0000_8000);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp");

    // saturation high, saturation low, sticky across beats, then clean
    push(32'h7FFF_FFFF, 1'b1);
    send(rep(16'h7FFF), rep(16'h7FFF), 1'b1, 32'h7FFF_FFFF);
    push(32'h8000_0000, 1'b1);
    send(rep(16'h8000), rep(16'h7FFF), 1'b1, 32'h8000_0000);
    push(32'h7FF0_001F, 1'b1);
    send(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 32'h7FFF_FFFF);
    send(rep(16'h8000), rep(16'h7FFF), 1'b1, 32'h0);
    push(32'h0000_8000, 1'b0);
    send(rep(16'h1000), rep(16'h2000), 1'b1, 32'h0);
    drain("sat");

    // rounding on single-lane instances
    r_valid = 1'b1;
    r_a = 16'h0001;
    r_b = 16'h0800;
    q_r0.push_back(32'h0000_0000);
    q_r1.push_back(32'h0000_0001);
    @(negedge clk);
    r_a = 16'hFFFF;
    q_r0.push_back(32'hFFFF_FFFF);
    q_r1.push_back(32'h0000_0000);
    @(negedge clk);
    r_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("round0_pending", 32'(q_r0.size()), 32'd0);
    check("round1_pending", 32'(q_r1.size()), 32'd0);

    // reset mid-vector discards the partial accumulation
    send(rep(16'h1000), rep(16'h1000), 1'b0, 32'h0000_0100);
    send(rep(16'h1000), rep(16'h1000), 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    push(32'h0000_0005, 1'b0);
    send(64'h0, 64'h0, 1'b1, 32'h0000_0005);
    drain("post_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
